// File: rtl/apb_m_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// apb_m_ctrl_pkg
// Shared types and defaults for the APB initiator slice.
//   APB_ADDR_W / APB_DATA_W : default bus widths (4-bit address, 8-bit data)
//   apb_m_state_e           : initiator FSM states
//   apb_cmd_t               : packed single-transfer command {write, addr, wdata}
// -----------------------------------------------------------------------------
package apb_m_ctrl_pkg;

    localparam int unsigned APB_ADDR_W = 4;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_m_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_m_ctrl_if.sv
// -----------------------------------------------------------------------------
// apb_m_ctrl_if
// APB bus bundle between one initiator and one target.
//   master modport : drives paddr/psel/penable/pwrite/pwdata, samples
//                    prdata/pready/pslverr
//   slave modport  : the mirror image
// -----------------------------------------------------------------------------
interface apb_m_ctrl_if
    import apb_m_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_m_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// apb_m_wdog
// Saturating ACCESS wait-state counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : clear counter to 0 (has priority over en_i)
//   en_i          : count one wait cycle at this edge
//   expired_o     : the count taken at this edge reaches TIMEOUT
//                   (never asserted when TIMEOUT == 0)
// -----------------------------------------------------------------------------
module apb_m_wdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned      CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             sat;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign sat     = (cnt_q == '1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !sat) begin
            cnt_d = cnt_inc;
        end
    end

    // Look-ahead compare so the controller can abort on the same edge the
    // counter reaches TIMEOUT.
    assign expired_o = (TIMEOUT != 0) && en_i && !clr_i && !sat && (cnt_inc == LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_m_ctrl.sv
// -----------------------------------------------------------------------------
// apb_m_ctrl
// APB initiator: accepts one read/write command on a valid/ready port, runs
// the APB SETUP/ACCESS sequence, and returns a one-cycle response strobe with
// read data and error/timeout status. All outputs are registered.
//   pclk, presetn      : bus clock, asynchronous active-low reset
//   cmd_valid/ready    : command handshake (accept when both high at an edge)
//   cmd_write/addr/wdata : command payload
//   rsp_valid          : one-cycle completion strobe
//   rsp_rdata          : read data (0 for writes and timeouts), held
//   rsp_err            : pslverr at completion, or 1 on timeout, held
//   rsp_timeout        : completion was a timeout abort
//   apb                : APB bus (master modport)
// -----------------------------------------------------------------------------
module apb_m_ctrl
    import apb_m_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    apb_m_ctrl_if.master      apb
);

    apb_m_state_e      state_q;
    logic              cmd_ready_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic              wd_clr;
    logic              wd_en;
    logic              wd_expired;

    // Counter is cleared on the SETUP->ACCESS edge and counts ACCESS edges
    // that see pready low.
    assign wd_clr = (state_q == SETUP);
    assign wd_en  = (state_q == ACCESS) && !apb.pready;

    apb_m_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (pclk),
        .rst_ni    (presetn),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            paddr_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    // Accept only once cmd_ready is already visible, so the
                    // first edge after reset merely raises cmd_ready.
                    if (cmd_valid && cmd_ready_q) begin
                        paddr_q     <= cmd_addr;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_write ? cmd_wdata : '0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    if (apb.pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= apb.pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : apb.prdata;
                    end else if (wd_expired) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end
                end

                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_m_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_m_ctrl
// Directed self-checking bench for apb_m_ctrl with TIMEOUT = 16.
// -----------------------------------------------------------------------------
module tb_apb_m_ctrl;

    logic       pclk;
    logic       presetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    apb_m_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    apb_m_ctrl #(
        .ADDR_W  (4),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Observations of the most recent do_xfer
    int         r_sel;
    int         r_en;
    logic       r_stable;
    logic       r_rsp;
    logic       r_idle_at_rsp;
    logic       r_after;
    logic [7:0] r_rdata;
    logic [7:0] r_hold;
    logic       r_err;
    logic       r_to;

    // Issue one command and act as the slave. Called and returning on a
    // negedge. Outside ACCESS the slave drives junk to show it is ignored.
    task automatic do_xfer(input apb_m_ctrl_pkg::apb_cmd_t c, input int waits,
                           input logic serr, input logic [7:0] rd);
        int   guard;
        int   wleft;
        logic [7:0] exp_pw;
        exp_pw        = c.write ? c.wdata : 8'h00;
        r_sel         = 0;
        r_en          = 0;
        r_stable      = 1'b1;
        r_rsp         = 1'b0;
        r_idle_at_rsp = 1'b0;
        r_rdata       = 8'h00;
        r_err         = 1'b0;
        r_to          = 1'b0;
        wleft         = waits;
        cmd_valid     = 1'b1;
        cmd_write     = c.write;
        cmd_addr      = c.addr;
        cmd_wdata     = c.wdata;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        if (guard >= 20) begin
            n_checks++;
            $display("FAIL accept_wait: cmd_ready never rose within 20 cycles");
        end
        @(negedge pclk);
        // Garbage on the command port must be ignored while busy
        cmd_valid = 1'b1;
        cmd_write = ~c.write;
        cmd_addr  = 4'hF;
        cmd_wdata = 8'h99;
        guard = 0;
        while (!r_rsp && guard < 100) begin
            if (bus.psel === 1'b1) r_sel++;
            if (bus.penable === 1'b1) r_en++;
            if (bus.psel === 1'b1 && (bus.paddr !== c.addr || bus.pwrite !== c.write ||
                                      bus.pwdata !== exp_pw)) r_stable = 1'b0;
            if (rsp_valid === 1'b1) begin
                r_rsp         = 1'b1;
                r_rdata       = rsp_rdata;
                r_err         = rsp_err;
                r_to          = rsp_timeout;
                r_idle_at_rsp = (bus.psel === 1'b0) && (bus.penable === 1'b0);
                cmd_valid     = 1'b0;
            end else begin
                if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
                    if (wleft > 0) begin
                        bus.pready  = 1'b0;
                        bus.prdata  = 8'hE7;
                        bus.pslverr = 1'b1;
                        wleft--;
                    end else begin
                        bus.pready  = 1'b1;
                        bus.prdata  = rd;
                        bus.pslverr = serr;
                    end
                end else begin
                    bus.pready  = 1'b1;
                    bus.prdata  = 8'h5A;
                    bus.pslverr = 1'b1;
                end
                @(negedge pclk);
                guard++;
            end
        end
        if (!r_rsp) begin
            n_checks++;
            $display("FAIL rsp_wait: rsp_valid never rose within 100 cycles");
        end
        cmd_valid   = 1'b0;
        bus.pready  = 1'b0;
        bus.prdata  = 8'h00;
        bus.pslverr = 1'b0;
        @(negedge pclk);
        r_after = rsp_valid;
        r_hold  = rsp_rdata;
    endtask

    task automatic test_reset();
        presetn     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 4'h0;
        cmd_wdata   = 8'h00;
        bus.pready  = 1'b0;
        bus.prdata  = 8'h00;
        bus.pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        n_checks++; if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, bus.psel, bus.penable, bus.pwrite} !== 7'b0)
            $display("FAIL reset_ctrl_bits: got %b expected 0000000",
                     {cmd_ready, rsp_valid, rsp_err, rsp_timeout, bus.psel, bus.penable, bus.pwrite});
        else n_pass++;
        n_checks++; if ({bus.paddr, bus.pwdata, rsp_rdata} !== 20'h0)
            $display("FAIL reset_data: got %h expected 00000", {bus.paddr, bus.pwdata, rsp_rdata});
        else n_pass++;
        presetn = 1'b1;
        @(negedge pclk);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_ready: got %b expected 1", cmd_ready); else n_pass++;
        n_checks++; if (bus.psel !== 1'b0) $display("FAIL post_reset_psel: got %b expected 0", bus.psel); else n_pass++;
    endtask

    task automatic test_zero_wait();
        do_xfer('{write: 1'b1, addr: 4'h1, wdata: 8'hAA}, 0, 1'b0, 8'h00);
        n_checks++; if (r_sel !== 2) $display("FAIL wr_psel_cycles: got %0d expected 2", r_sel); else n_pass++;
        n_checks++; if (r_en !== 1) $display("FAIL wr_penable_cycles: got %0d expected 1", r_en); else n_pass++;
        n_checks++; if (r_stable !== 1'b1) $display("FAIL wr_bus_stable: got %b expected 1", r_stable); else n_pass++;
        n_checks++; if ({r_rdata, r_err, r_to} !== 10'h0) $display("FAIL wr_rsp: got %h expected 000", {r_rdata, r_err, r_to}); else n_pass++;
        do_xfer('{write: 1'b0, addr: 4'h1, wdata: 8'h00}, 0, 1'b0, 8'hAA);
        n_checks++; if (r_sel !== 2) $display("FAIL rd_psel_cycles: got %0d expected 2", r_sel); else n_pass++;
        n_checks++; if (r_en !== 1) $display("FAIL rd_penable_cycles: got %0d expected 1", r_en); else n_pass++;
        n_checks++; if (r_stable !== 1'b1) $display("FAIL rd_bus_stable: got %b expected 1", r_stable); else n_pass++;
        n_checks++; if (r_rdata !== 8'hAA) $display("FAIL rd_rdata: got %h expected aa", r_rdata); else n_pass++;
        n_checks++; if (r_err !== 1'b0) $display("FAIL rd_err: got %b expected 0", r_err); else n_pass++;
        n_checks++; if (r_after !== 1'b0) $display("FAIL rd_rsp_one_cycle: got %b expected 0", r_after); else n_pass++;
        n_checks++; if (r_idle_at_rsp !== 1'b1) $display("FAIL rd_bus_idle_at_rsp: got %b expected 1", r_idle_at_rsp); else n_pass++;
    endtask

    task automatic test_wait_states();
        do_xfer('{write: 1'b0, addr: 4'h3, wdata: 8'h00}, 3, 1'b0, 8'hCC);
        n_checks++; if (r_en !== 4) $display("FAIL ws_penable_cycles: got %0d expected 4", r_en); else n_pass++;
        n_checks++; if (r_sel !== 5) $display("FAIL ws_psel_cycles: got %0d expected 5", r_sel); else n_pass++;
        n_checks++; if (r_stable !== 1'b1) $display("FAIL ws_bus_stable: got %b expected 1", r_stable); else n_pass++;
        n_checks++; if (r_rdata !== 8'hCC) $display("FAIL ws_rdata: got %h expected cc", r_rdata); else n_pass++;
        n_checks++; if (r_to !== 1'b0) $display("FAIL ws_timeout: got %b expected 0", r_to); else n_pass++;
        n_checks++; if (r_hold !== 8'hCC) $display("FAIL ws_rdata_hold: got %h expected cc", r_hold); else n_pass++;
    endtask

    task automatic test_slave_err();
        do_xfer('{write: 1'b1, addr: 4'hA, wdata: 8'hFF}, 0, 1'b1, 8'h00);
        n_checks++; if (r_err !== 1'b1) $display("FAIL serr_err: got %b expected 1", r_err); else n_pass++;
        n_checks++; if (r_to !== 1'b0) $display("FAIL serr_timeout: got %b expected 0", r_to); else n_pass++;
        n_checks++; if (r_rdata !== 8'h00) $display("FAIL serr_rdata: got %h expected 00", r_rdata); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL serr_ready_after: got %b expected 1", cmd_ready); else n_pass++;
        do_xfer('{write: 1'b0, addr: 4'h6, wdata: 8'h00}, 1, 1'b0, 8'h11);
        n_checks++; if ({r_rdata, r_err} !== 9'h022) $display("FAIL serr_next_rd: got %h expected 022", {r_rdata, r_err}); else n_pass++;
    endtask

    task automatic test_timeout();
        do_xfer('{write: 1'b0, addr: 4'h5, wdata: 8'h00}, 1000, 1'b0, 8'h77);
        n_checks++; if (r_en !== 16) $display("FAIL to_access_cycles: got %0d expected 16", r_en); else n_pass++;
        n_checks++; if (r_idle_at_rsp !== 1'b1) $display("FAIL to_bus_idle: got %b expected 1", r_idle_at_rsp); else n_pass++;
        n_checks++; if ({r_err, r_to} !== 2'b11) $display("FAIL to_status: got %b expected 11", {r_err, r_to}); else n_pass++;
        n_checks++; if (r_rdata !== 8'h00) $display("FAIL to_rdata: got %h expected 00", r_rdata); else n_pass++;
        do_xfer('{write: 1'b0, addr: 4'h2, wdata: 8'h00}, 0, 1'b0, 8'hBB);
        n_checks++; if (r_rdata !== 8'hBB) $display("FAIL to_next_rdata: got %h expected bb", r_rdata); else n_pass++;
        n_checks++; if ({r_err, r_to} !== 2'b00) $display("FAIL to_next_status: got %b expected 00", {r_err, r_to}); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        int   guard;
        logic saw_rsp;
        bus.pready = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = 4'h4;
        cmd_wdata  = 8'h00;
        cmd_valid  = 1'b1;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        if (guard >= 20) begin
            n_checks++;
            $display("FAIL rm_accept_wait: cmd_ready never rose within 20 cycles");
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        n_checks++; if ({bus.psel, bus.penable} !== 2'b11) $display("FAIL rm_in_access: got %b expected 11", {bus.psel, bus.penable}); else n_pass++;
        #2 presetn = 1'b0;
        #1;
        n_checks++; if ({bus.psel, bus.penable} !== 2'b00) $display("FAIL rm_async_drop: got %b expected 00", {bus.psel, bus.penable}); else n_pass++;
        saw_rsp = 1'b0;
        @(negedge pclk);
        if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        n_checks++; if (saw_rsp !== 1'b0) $display("FAIL rm_no_rsp: got %b expected 0", saw_rsp); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rm_ready_after: got %b expected 1", cmd_ready); else n_pass++;
        do_xfer('{write: 1'b0, addr: 4'h4, wdata: 8'h00}, 0, 1'b0, 8'h3C);
        n_checks++; if (r_rdata !== 8'h3C) $display("FAIL rm_fresh_rdata: got %h expected 3c", r_rdata); else n_pass++;
        n_checks++; if (r_en !== 1) $display("FAIL rm_fresh_penable: got %0d expected 1", r_en); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_slave_err();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_m_ctrl.md
Name: apb_m_ctrl

Overview:
APB initiator (master) for the 4-bit-address / 8-bit-data APB bus served by apb_s_top. It accepts single read/write commands on a valid/ready command port and sequences the APB SETUP and ACCESS phases. It waits on pready, then returns read data plus an error/timeout status on a one-cycle response strobe. It replaces hand-driven bus tasks as the bus-side front end for firmware-style sequencers and benches.

Parameters:
ADDR_W, 4, paddr / cmd_addr width
DATA_W, 8, pwdata / prdata / cmd_wdata / rsp_rdata width
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  in  1  bus clock, all logic on rising edge
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr sampled at completion, or 1 on timeout
rsp_timeout  out  1  completion was a timeout abort
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (presetn low, asynchronous): state IDLE; all outputs 0, including cmd_ready, paddr, pwdata, pwrite, psel, penable and all rsp_*; wait counter 0. Reset mid-transfer drops psel/penable immediately. No response is issued for the aborted command.
- All outputs are registered. cmd_ready is 1 only in IDLE and out of reset, i.e. cmd_ready = (state==IDLE).
- State machine (enum IDLE, SETUP, ACCESS):
  - IDLE: when cmd_valid at an edge, latch cmd_addr→paddr, cmd_write→pwrite, cmd_wdata→pwdata (0 for reads). Drive psel=1, penable=0 and go to SETUP.
  - SETUP: lasts exactly 1 cycle. Next edge: penable=1, go to ACCESS, wait counter cleared.
  - ACCESS on a rising edge with pready=1: psel=0, penable=0, go to IDLE. In the same edge set rsp_valid=1, rsp_err=pslverr, rsp_timeout=0, and rsp_rdata = prdata for reads, 0 for writes.
  - ACCESS on a rising edge with pready=0: increment the wait counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, abort: psel=0, penable=0, go to IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Latency: zero-wait slave gives accept edge E, SETUP after E, ACCESS after E+1, rsp_valid high after E+2 for one cycle. Next cmd acceptance is at E+3 at the earliest.
- paddr, pwrite and pwdata hold stable from SETUP through the end of ACCESS. In IDLE they hold their last value (no toggling).
- rsp_rdata and rsp_err hold their value after rsp_valid falls, until the next completion.
- The wait counter saturates and is width-sized to hold TIMEOUT. pready/pslverr/prdata are ignored outside ACCESS.
- cmd_* inputs are ignored while cmd_ready=0. The block does no address-range checking; the slave's pslverr is passed through.

Decomposition:
- apb_pkg holds ADDR_W/DATA_W defaults, typedef enum logic[1:0] apb_m_state_e {IDLE, SETUP, ACCESS}, and a packed apb_cmd_t {write, addr, wdata}.
- One sub-module, apb_m_wdog: wait counter with clear, count enable and an expired flag, parameterised by TIMEOUT.
- The FSM and output registers stay in apb_m_ctrl.

Test Plan:
- Reset then idle: presetn low for 2 cycles → all outputs 0. After release, cmd_ready=1 and psel=0.
- Zero-wait write/read: write 0xAA to addr 0x1, then read addr 0x1 with the slave model returning 0xAA. Required per transfer: psel high 2 cycles, penable high 1 cycle, paddr=0x1 stable throughout. Read gives rsp_valid 1 cycle with rsp_rdata=0xAA, rsp_err=0.
- Wait states: slave holds pready low 3 cycles on a read of addr 0x3 returning 0xCC → penable high 4 cycles. rsp_valid follows the edge where pready=1 with rsp_rdata=0xCC, rsp_timeout=0.
- Slave error: write 0xFF to addr 0xA with the slave asserting pslverr at completion → rsp_err=1, rsp_timeout=0. Bus returns to IDLE and the next command is accepted.
- Timeout: TIMEOUT=16, pready stuck low → after 16 ACCESS cycles psel=penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. A subsequent read to addr 0x2 with a zero-wait slave returns 0xBB correctly.
- Reset mid-ACCESS: assert presetn low during a waited transfer → psel/penable fall without a clock edge and no rsp_valid is produced. After release, a fresh read completes normally.
